// File: rtl/noc_vc_allocator.sv
// noc_vc_allocator -- virtual-channel allocator for a 5-port wormhole router.
//
// Separable input-first round-robin allocation:
//   stage 1: each requesting input VC picks one free downstream VC on its
//            routed output port, scanning up from its own pointer;
//   stage 2: each downstream VC picks one of the inputs that chose it,
//            scanning up from its own pointer.
// Grants are combinational (zero latency); availability and pointers are
// registered.
//
// Ports:
//   clk                   rising-edge clock
//   rst                   synchronous reset, active low
//   idle_downstream_vc_i  [VC_TOTAL]  release pulse per downstream VC
//   vc_to_allocate_i      [VC_TOTAL]  allocation request per input VC
//   out_port_i            [VC_TOTAL]  routed output port per input VC
//   vc_new_o              [VC_TOTAL]  granted VC number within the port
//   vc_valid_o            [VC_TOTAL]  grant strobe per input VC

package noc_params;
  localparam int PORT_NUM = 5;
  localparam int VC_NUM   = 2;
  localparam int VC_TOTAL = PORT_NUM * VC_NUM;
  localparam int VC_SIZE  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

  // 3 bits so that out-of-range encodings (5..7) can arrive and be rejected.
  typedef logic [2:0] port_t;
  localparam port_t LOCAL = 3'd0;
  localparam port_t NORTH = 3'd1;
  localparam port_t SOUTH = 3'd2;
  localparam port_t WEST  = 3'd3;
  localparam port_t EAST  = 3'd4;
endpackage

// Stage-1 arbiter for one input VC: first free VC on the routed port,
// scanning upward from ptr_i with wrap.
module vc_in_arb #(
  parameter int PORT_NUM = 5,
  parameter int VC_NUM   = 2,
  parameter int VC_TOTAL = 10,
  parameter int VC_SIZE  = 1,
  parameter int IDX_W    = 4
) (
  input  logic                  req_i,
  input  noc_params::port_t     port_i,
  input  logic [VC_SIZE-1:0]    ptr_i,
  input  logic [VC_TOTAL-1:0]   avail_i,
  output logic                  sel_vld_o,
  output logic [VC_SIZE-1:0]    sel_vc_o,
  output logic [IDX_W-1:0]      sel_idx_o
);
  int               k;
  logic [IDX_W-1:0] j;

  always_comb begin
    sel_vld_o = 1'b0;
    sel_vc_o  = '0;
    sel_idx_o = '0;
    k         = 0;
    j         = '0;
    // Ports beyond the last real port are dropped before any indexing.
    if (req_i && (int'(port_i) < PORT_NUM)) begin
      for (int off = 0; off < VC_NUM; off++) begin
        k = int'(ptr_i) + off;
        if (k >= VC_NUM) k = k - VC_NUM;
        j = IDX_W'(int'(port_i) * VC_NUM + k);
        if (!sel_vld_o && avail_i[j]) begin
          sel_vld_o = 1'b1;
          sel_vc_o  = VC_SIZE'(k);
          sel_idx_o = j;
        end
      end
    end
  end
endmodule

module noc_vc_allocator #(
  parameter int  VC_TOTAL = noc_params::VC_TOTAL,
  parameter int  PORT_NUM = noc_params::PORT_NUM,
  parameter int  VC_NUM   = noc_params::VC_NUM,
  localparam int VC_SIZE  = noc_params::VC_SIZE
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [VC_TOTAL-1:0]                 idle_downstream_vc_i,
  input  logic [VC_TOTAL-1:0]                 vc_to_allocate_i,
  input  noc_params::port_t [VC_TOTAL-1:0]    out_port_i,
  output logic [VC_SIZE-1:0]                  vc_new_o [VC_TOTAL],
  output logic [VC_TOTAL-1:0]                 vc_valid_o
);
  localparam int IDX_W = $clog2(VC_TOTAL);

  // State
  logic [VC_TOTAL-1:0] avail_q, avail_d;
  logic [VC_SIZE-1:0]  in_ptr_q  [VC_TOTAL];
  logic [VC_SIZE-1:0]  in_ptr_d  [VC_TOTAL];
  logic [IDX_W-1:0]    out_ptr_q [VC_TOTAL];
  logic [IDX_W-1:0]    out_ptr_d [VC_TOTAL];

  // Stage 1 results per input
  logic [VC_TOTAL-1:0] s1_vld;
  logic [VC_SIZE-1:0]  s1_vc  [VC_TOTAL];
  logic [IDX_W-1:0]    s1_idx [VC_TOTAL];

  // Stage 2 results per downstream VC / per input
  logic [VC_TOTAL-1:0] out_gnt;
  logic [IDX_W-1:0]    out_win [VC_TOTAL];
  logic [VC_TOTAL-1:0] in_gnt;

  genvar g;
  generate
    for (g = 0; g < VC_TOTAL; g++) begin : g_in
      vc_in_arb #(
        .PORT_NUM (PORT_NUM),
        .VC_NUM   (VC_NUM),
        .VC_TOTAL (VC_TOTAL),
        .VC_SIZE  (VC_SIZE),
        .IDX_W    (IDX_W)
      ) u_arb (
        .req_i     (vc_to_allocate_i[g]),
        .port_i    (out_port_i[g]),
        .ptr_i     (in_ptr_q[g]),
        .avail_i   (avail_q),
        .sel_vld_o (s1_vld[g]),
        .sel_vc_o  (s1_vc[g]),
        .sel_idx_o (s1_idx[g])
      );
    end
  endgenerate

  // Stage 2: per downstream VC, first chooser at or after out_ptr.
  int               s2_i;
  logic [IDX_W-1:0] s2_ii;

  always_comb begin
    out_gnt = '0;
    s2_i    = 0;
    s2_ii   = '0;
    for (int j = 0; j < VC_TOTAL; j++) begin
      out_win[j] = '0;
      for (int off = 0; off < VC_TOTAL; off++) begin
        s2_i = int'(out_ptr_q[j]) + off;
        if (s2_i >= VC_TOTAL) s2_i = s2_i - VC_TOTAL;
        s2_ii = IDX_W'(s2_i);
        if (!out_gnt[j] && s1_vld[s2_ii] && (s1_idx[s2_ii] == IDX_W'(j))) begin
          out_gnt[j] = 1'b1;
          out_win[j] = s2_ii;
        end
      end
    end
  end

  // Grant fan-back to inputs, outputs and next state.
  int nxt;

  always_comb begin
    in_gnt     = '0;
    vc_valid_o = '0;
    avail_d    = avail_q;
    nxt        = 0;
    for (int i = 0; i < VC_TOTAL; i++) begin
      vc_new_o[i] = '0;
      in_ptr_d[i] = in_ptr_q[i];
      // An input wins only if the VC it chose also chose it back.
      in_gnt[i] = s1_vld[i] && out_gnt[s1_idx[i]] &&
                  (out_win[s1_idx[i]] == IDX_W'(i));
      if (rst && in_gnt[i]) begin
        vc_valid_o[i] = 1'b1;
        vc_new_o[i]   = s1_vc[i];
      end
      if (in_gnt[i]) begin
        nxt = int'(s1_vc[i]) + 1;
        if (nxt >= VC_NUM) nxt = 0;
        in_ptr_d[i] = VC_SIZE'(nxt);
      end
    end
    for (int j = 0; j < VC_TOTAL; j++) begin
      out_ptr_d[j] = out_ptr_q[j];
      // Grant beats a simultaneous release: the VC stays busy.
      if (out_gnt[j]) begin
        avail_d[j] = 1'b0;
        nxt = int'(out_win[j]) + 1;
        if (nxt >= VC_TOTAL) nxt = 0;
        out_ptr_d[j] = IDX_W'(nxt);
      end else if (idle_downstream_vc_i[j]) begin
        avail_d[j] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      avail_q <= '1;
      for (int i = 0; i < VC_TOTAL; i++) begin
        in_ptr_q[i]  <= '0;
        out_ptr_q[i] <= '0;
      end
    end else begin
      avail_q   <= avail_d;
      in_ptr_q  <= in_ptr_d;
      out_ptr_q <= out_ptr_d;
    end
  end
endmodule

// File: tb/tb_noc_vc_allocator.sv
// Directed bench for noc_vc_allocator: reset, single grants, release,
// contention, round-robin fairness, invalid requests, random guarantees
// and reset in mid-operation.
module tb_noc_vc_allocator;
  localparam int VT = noc_params::VC_TOTAL;
  localparam int SZ = noc_params::VC_SIZE;

  logic                          clk;
  logic                          rst;
  logic [VT-1:0]                 idle;
  logic [VT-1:0]                 req;
  noc_params::port_t [VT-1:0]    out_port;
  logic [SZ-1:0]                 vc_new [VT];
  logic [VT-1:0]                 vc_valid;
  logic [VT*SZ-1:0]              new_vec;

  int n_chk = 0;
  int n_err = 0;

  noc_vc_allocator dut (
    .clk                  (clk),
    .rst                  (rst),
    .idle_downstream_vc_i (idle),
    .vc_to_allocate_i     (req),
    .out_port_i           (out_port),
    .vc_new_o             (vc_new),
    .vc_valid_o           (vc_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    new_vec = '0;
    for (int i = 0; i < VT; i++) new_vec[i*SZ +: SZ] = vc_new[i];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Settle, check grant mask and packed vc_new, then advance one cycle.
  task automatic step_chk(input string tag, input logic [VT-1:0] ev, input logic [VT*SZ-1:0] en);
    #2;
    chk({tag, "_valid"}, 32'(vc_valid), 32'(ev));
    chk({tag, "_new"},   32'(new_vec),  32'(en));
    @(posedge clk); #1;
  endtask

  logic [VT-1:0] avail_m, claimed;
  int            j;

  initial begin
    rst = 1'b0; req = '0; idle = '0; out_port = '0;

    // Reset with random requests: outputs forced low.
    for (int c = 0; c < 2; c++) begin
      req = VT'($urandom);
      for (int i = 0; i < VT; i++) out_port[i] = 3'($urandom_range(0, 7));
      step_chk("reset", '0, '0);
    end
    rst = 1'b1; req = '0; idle = '0;

    // Contention on NORTH (VCs 2,3).
    out_port[2] = noc_params::NORTH; out_port[4] = noc_params::NORTH;
    req = 10'b00_0001_0100; step_chk("cont1", 10'b00_0000_0100, 10'b0);
    req = 10'b00_0001_0000; step_chk("cont2", 10'b00_0001_0000, 10'b00_0001_0000);
    req = 10'b00_0001_0100; step_chk("cont_full", '0, '0);
    req = '0; idle = 10'b00_0000_1100; step_chk("rel_north", '0, '0);
    idle = '0;

    // Single requester on EAST (VCs 8,9) and release behaviour.
    out_port[0] = noc_params::EAST;
    req = 10'b1; step_chk("east1", 10'b1, 10'b0);
    step_chk("east2", 10'b1, 10'b1);
    step_chk("east_full", '0, '0);
    req = '0; idle[8] = 1'b1; step_chk("rel8", '0, '0);
    idle = '0; req = 10'b1; step_chk("east_after_rel", 10'b1, 10'b0);
    req = '0; idle[9] = 1'b1; step_chk("rel9", '0, '0);
    req = 10'b1; step_chk("gnt_rel_same", 10'b1, 10'b1);
    idle = '0; step_chk("gnt_beats_rel", '0, '0);
    req = '0; idle = 10'b11_0000_0000; step_chk("rel_east", '0, '0);
    idle = '0;

    // Pin SOUTH VC 5 busy so SOUTH VC 4 alone carries the fairness test.
    out_port[5] = noc_params::SOUTH;
    req = 10'b00_0010_0000; step_chk("fill4", 10'b00_0010_0000, 10'b0);
    step_chk("fill5", 10'b00_0010_0000, 10'b00_0010_0000);
    req = '0; idle[4] = 1'b1; step_chk("rel4", '0, '0);
    idle = '0;

    // Fairness: inputs 0,3,7 on SOUTH, VC 4 released after each grant.
    out_port[0] = noc_params::SOUTH; out_port[3] = noc_params::SOUTH; out_port[7] = noc_params::SOUTH;
    req = 10'b00_1000_1001;
    step_chk("fair1", 10'b00_1000_0000, '0);
    idle[4] = 1'b1; step_chk("fair1_rel", '0, '0); idle = '0;
    step_chk("fair2", 10'b00_0000_0001, '0);
    idle[4] = 1'b1; step_chk("fair2_rel", '0, '0); idle = '0;
    step_chk("fair3", 10'b00_0000_1000, '0);
    idle[4] = 1'b1; step_chk("fair3_rel", '0, '0); idle = '0;
    step_chk("fair4", 10'b00_1000_0000, '0);
    req = '0; idle = 10'b00_0011_0000; step_chk("rel_south", '0, '0);
    idle = '0;

    // Invalid port codes and idle inputs are ignored.
    out_port[1] = 3'd5; out_port[2] = 3'd7; out_port[6] = noc_params::EAST;
    req = 10'b00_0000_0110; step_chk("invalid", '0, '0);
    req = 10'b00_0100_0000; step_chk("after_invalid", 10'b00_0100_0000, '0);
    req = '0; idle = '1; step_chk("rel_all", '0, '0);
    idle = '0;

    // Random stimulus: check the allocation guarantees every cycle.
    avail_m = '1;
    for (int c = 0; c < 10; c++) begin
      req  = VT'($urandom);
      idle = VT'($urandom) & VT'($urandom);
      for (int i = 0; i < VT; i++) out_port[i] = 3'($urandom_range(0, 6));
      #2;
      claimed = '0;
      chk("rnd_new_idle", 32'(new_vec & ~vc_valid), 32'd0);
      for (int i = 0; i < VT; i++) begin
        if (vc_valid[i]) begin
          chk("rnd_req_ok", 32'(req[i] && (out_port[i] < 3'd5)), 32'd1);
          j = int'(out_port[i]) * noc_params::VC_NUM + int'(vc_new[i]);
          if (j < VT) begin
            chk("rnd_avail", 32'(avail_m[j]), 32'd1);
            chk("rnd_dup", 32'(claimed[j]), 32'd0);
            claimed[j] = 1'b1;
          end
        end
      end
      for (int k = 0; k < VT; k++) begin
        if (claimed[k]) avail_m[k] = 1'b0;
        else if (idle[k]) avail_m[k] = 1'b1;
      end
      @(posedge clk); #1;
    end

    // Reset mid-operation clears outputs and state.
    rst = 1'b0; idle = '0; req = '1;
    for (int i = 0; i < VT; i++) out_port[i] = noc_params::EAST;
    step_chk("mid_reset", '0, '0);
    rst = 1'b1; req = 10'b1;
    step_chk("post_reset", 10'b1, 10'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
